// File: rtl/gyro_pkg.sv
// gyro_pkg: shared types and widths for the gyro integrator.
//   cal_state_t : calibration / run state machine encoding
//   RATE_W      : raw angular-rate word width
//   ACC_W       : per-axis angle accumulator width
//   ANGLE_W     : published angle width
package gyro_pkg;

  localparam int RATE_W  = 16;
  localparam int ACC_W   = 32;
  localparam int ANGLE_W = 16;

  typedef enum logic [1:0] {
    CAL_CLEAR,
    CAL_ACCUM,
    CAL_BIAS,
    RUN
  } cal_state_t;

endpackage

// File: rtl/gyro_integrator_if.sv
// gyro_integrator_if: bundle between the rate source / camera consumer and
// the gyro integrator.
//   gx_in/gy_in/gz_in : signed raw rates (asynchronous to the integrator clock)
//   cal_start_in      : one-cycle pulse, restart bias calibration
//   zero_in           : one-cycle pulse, zero all angles while running
//   pitch/roll/yaw_out: signed integrated angles
//   valid_out         : one-cycle strobe when the angles update
//   calibrated_out    : high while integrating
// master = side that supplies rates/commands and consumes angles;
// slave  = the integrator.
interface gyro_integrator_if;
  import gyro_pkg::*;

  logic signed [RATE_W-1:0]  gx_in;
  logic signed [RATE_W-1:0]  gy_in;
  logic signed [RATE_W-1:0]  gz_in;
  logic                      cal_start_in;
  logic                      zero_in;
  logic signed [ANGLE_W-1:0] pitch_out;
  logic signed [ANGLE_W-1:0] roll_out;
  logic signed [ANGLE_W-1:0] yaw_out;
  logic                      valid_out;
  logic                      calibrated_out;

  modport master (
    output gx_in, gy_in, gz_in, cal_start_in, zero_in,
    input  pitch_out, roll_out, yaw_out, valid_out, calibrated_out
  );

  modport slave (
    input  gx_in, gy_in, gz_in, cal_start_in, zero_in,
    output pitch_out, roll_out, yaw_out, valid_out, calibrated_out
  );

endinterface

// File: rtl/gyro_axis_integrator.sv
// gyro_axis_integrator: one axis of the integrator.
// Resynchronises the raw rate, accumulates the calibration sum, derives the
// zero-rate bias, integrates the bias-corrected, deadbanded rate and holds
// the published angle. All sequencing comes from the parent's state machine.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   raw              : raw signed rate (asynchronous)
//   clear            : clear calibration sum and accumulator
//   accum_en         : add current sample to the calibration sum
//   bias_load        : latch bias from the calibration sum
//   run_tick         : integrate current sample
//   acc_zero         : clear accumulator
//   out_load         : publish accumulator into angle
//   out_clear        : force angle to 0
//   angle            : published angle
module gyro_axis_integrator
  import gyro_pkg::*;
#(
  parameter int CAL_LOG2    = 8,
  parameter int DEADBAND    = 16,
  parameter int SCALE_SHIFT = 6
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic signed [RATE_W-1:0]  raw,
  input  logic                      clear,
  input  logic                      accum_en,
  input  logic                      bias_load,
  input  logic                      run_tick,
  input  logic                      acc_zero,
  input  logic                      out_load,
  input  logic                      out_clear,
  output logic signed [ANGLE_W-1:0] angle
);

  localparam int SUM_W = RATE_W + CAL_LOG2;
  localparam logic signed [RATE_W:0] DB_POS = (RATE_W+1)'(DEADBAND);
  localparam logic signed [RATE_W:0] DB_NEG = -DB_POS;

  logic signed [RATE_W-1:0]  sync1_reg, sync2_reg;
  logic signed [SUM_W-1:0]   sum_reg;
  logic signed [RATE_W-1:0]  bias_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic signed [ANGLE_W-1:0] angle_reg;

  logic signed [RATE_W:0]    diff;
  logic signed [RATE_W:0]    d_gated;

  // 17-bit difference cannot overflow for any 16-bit sample and bias.
  assign diff    = {sync2_reg[RATE_W-1], sync2_reg} - {bias_reg[RATE_W-1], bias_reg};
  assign d_gated = (diff >= DB_NEG && diff <= DB_POS) ? '0 : diff;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_reg  <= '0;
      bias_reg <= '0;
      acc_reg  <= '0;
    end else begin
      if (clear) begin
        sum_reg <= '0;
      end else if (accum_en) begin
        sum_reg <= sum_reg + {{CAL_LOG2{sync2_reg[RATE_W-1]}}, sync2_reg};
      end
      // Top RATE_W bits of the sum equal sum >>> CAL_LOG2 (floor average).
      if (bias_load) begin
        bias_reg <= sum_reg[CAL_LOG2 +: RATE_W];
      end
      if (clear || acc_zero) begin
        acc_reg <= '0;
      end else if (run_tick) begin
        acc_reg <= acc_reg + {{(ACC_W-RATE_W-1){d_gated[RATE_W]}}, d_gated};
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      angle_reg <= '0;
    end else if (out_clear) begin
      angle_reg <= '0;
    end else if (out_load) begin
      angle_reg <= acc_reg[SCALE_SHIFT +: ANGLE_W];
    end
  end

  assign angle = angle_reg;

endmodule

// File: rtl/gyro_integrator.sv
// gyro_integrator: three-axis gyro rate integrator.
// Generates the sample tick, runs the calibrate/run state machine and drives
// three per-axis integrators (gx->pitch, gy->roll, gz->yaw).
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset
//   bus      : slave side of gyro_integrator_if (rates, commands, angles)
module gyro_integrator
  import gyro_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_HZ   = 1000,
  parameter int CAL_LOG2    = 8,
  parameter int DEADBAND    = 16,
  parameter int SCALE_SHIFT = 6
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  gyro_integrator_if.slave bus
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = $clog2(DIV);
  localparam int CAL_N = 1 << CAL_LOG2;

  cal_state_t            state_reg;
  logic [CNT_W-1:0]      tick_cnt_reg;
  logic [CAL_LOG2:0]     cal_cnt_reg;
  logic                  calibrated_reg;
  logic                  upd_reg;
  logic                  valid_reg;
  logic                  tick;

  logic                  clear, accum_en, bias_load, run_tick, acc_zero;
  logic                  out_load, out_clear, run_sample;

  // Free-running divider; deliberately untouched by calibrate/zero commands.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
    end
  end

  assign tick = (tick_cnt_reg == CNT_W'(DIV - 1));

  // cal_start_in overrides everything, including a coincident tick.
  assign clear      = (state_reg == CAL_CLEAR);
  assign accum_en   = (state_reg == CAL_ACCUM) && tick && !bus.cal_start_in;
  assign bias_load  = (state_reg == CAL_BIAS) && !bus.cal_start_in;
  assign run_sample = (state_reg == RUN) && tick && !bus.cal_start_in;
  // A zero on a tick discards that tick's rate but still publishes.
  assign run_tick   = run_sample && !bus.zero_in;
  assign acc_zero   = (state_reg == RUN) && bus.zero_in && !bus.cal_start_in;
  assign out_load   = upd_reg && (state_reg == RUN) && !bus.cal_start_in;
  assign out_clear  = clear || bus.cal_start_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg      <= CAL_CLEAR;
      cal_cnt_reg    <= '0;
      calibrated_reg <= 1'b0;
      upd_reg        <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      upd_reg   <= run_sample;
      valid_reg <= out_load;
      if (bus.cal_start_in) begin
        state_reg      <= CAL_CLEAR;
        cal_cnt_reg    <= '0;
        calibrated_reg <= 1'b0;
      end else begin
        case (state_reg)
          CAL_CLEAR: begin
            cal_cnt_reg <= '0;
            state_reg   <= CAL_ACCUM;
          end
          CAL_ACCUM: begin
            if (tick) begin
              cal_cnt_reg <= cal_cnt_reg + 1'b1;
              if (cal_cnt_reg == (CAL_LOG2+1)'(CAL_N - 1)) begin
                state_reg <= CAL_BIAS;
              end
            end
          end
          CAL_BIAS: begin
            state_reg      <= RUN;
            calibrated_reg <= 1'b1;
          end
          RUN: begin
            state_reg <= RUN;
          end
          default: begin
            state_reg      <= CAL_CLEAR;
            calibrated_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  logic signed [RATE_W-1:0]  raw   [3];
  logic signed [ANGLE_W-1:0] angle [3];

  assign raw[0] = bus.gx_in;
  assign raw[1] = bus.gy_in;
  assign raw[2] = bus.gz_in;

  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    gyro_axis_integrator #(
      .CAL_LOG2   (CAL_LOG2),
      .DEADBAND   (DEADBAND),
      .SCALE_SHIFT(SCALE_SHIFT)
    ) u_axis (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .raw      (raw[gi]),
      .clear    (clear),
      .accum_en (accum_en),
      .bias_load(bias_load),
      .run_tick (run_tick),
      .acc_zero (acc_zero),
      .out_load (out_load),
      .out_clear(out_clear),
      .angle    (angle[gi])
    );
  end

  assign bus.pitch_out      = angle[0];
  assign bus.roll_out       = angle[1];
  assign bus.yaw_out        = angle[2];
  assign bus.valid_out      = valid_reg;
  assign bus.calibrated_out = calibrated_reg;

endmodule

// File: tb/tb_gyro_integrator.sv
// tb_gyro_integrator: self-checking bench for gyro_integrator at DIV = 8.
// A behavioural model keeps per-axis bias and accumulator as plain integers
// and predicts the published angles after every sample tick.
module tb_gyro_integrator;

  localparam int DIV = 8;
  localparam int NCAL = 256;

  logic clk_in = 1'b0;
  logic rst_n_in;
  always #5 clk_in = ~clk_in;

  gyro_integrator_if bus ();

  gyro_integrator #(
    .CLK_HZ     (100_000_000),
    .SAMPLE_HZ  (12_500_000),
    .CAL_LOG2   (8),
    .DEADBAND   (16),
    .SCALE_SHIFT(6)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Edges since reset release; the sample tick lands on every DIV-th edge.
  int e;
  always @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) e <= 0;
    else           e <= e + 1;

  // Counts valid strobes so a window can be checked for silence.
  int valid_seen = 0;
  always @(negedge clk_in)
    if (bus.valid_out === 1'b1) valid_seen <= valid_seen + 1;

  // Reference model state.
  int          bias_m [3];
  logic signed [31:0] acc_m [3];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int angle_m(input int i);
    logic signed [31:0] a;
    a = acc_m[i];
    return int'($signed(a[21:6]));
  endfunction

  task automatic wait_edge();
    @(posedge clk_in);
    #1;
  endtask

  // Park in a cycle where changed inputs still settle before the next tick.
  task automatic align_safe();
    while (!((e % DIV) >= 2 && (e % DIV) <= 5)) wait_edge();
  endtask

  task automatic set_in(input int x, input int y, input int z);
    bus.gx_in = 16'(x);
    bus.gy_in = 16'(y);
    bus.gz_in = 16'(z);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pitch"}, bus.pitch_out, 0);
    check({tag, "_roll"}, bus.roll_out, 0);
    check({tag, "_yaw"}, bus.yaw_out, 0);
    check({tag, "_valid"}, bus.valid_out, 0);
    check({tag, "_cal"}, bus.calibrated_out, 0);
  endtask

  function automatic int floor_div256(input int s);
    if (s >= 0) return s / NCAL;
    return -((-s + NCAL - 1) / NCAL);
  endfunction

  // Calibration starting from CAL_CLEAR entered at edge e0.
  // First NCAL-1 samples use (x0,y0,z0); the last sample uses (x1,y1,z1).
  task automatic calibrate(input int e0, input int x0, input int y0, input int z0,
                           input int x1, input int y1, input int z1);
    int cnt;
    int v0;
    int xs[3];
    int xl[3];
    xs = '{x0, y0, z0};
    xl = '{x1, y1, z1};
    v0 = valid_seen;
    set_in(x0, y0, z0);
    cnt = 0;
    while (cnt < NCAL) begin
      wait_edge();
      if ((e % DIV) == 0 && e >= e0 + 2) begin
        cnt++;
        if (cnt == NCAL - 1) set_in(x1, y1, z1);
      end
    end
    check("cal_pending", bus.calibrated_out, 0);
    check("cal_quiet_pitch", bus.pitch_out, 0);
    wait_edge();
    check("cal_done", bus.calibrated_out, 1);
    check("cal_no_valid", valid_seen - v0, 0);
    for (int i = 0; i < 3; i++) begin
      bias_m[i] = floor_div256((NCAL - 1) * xs[i] + xl[i]);
      acc_m[i]  = '0;
    end
  endtask

  task automatic run_ticks(input int n, input int x, input int y, input int z);
    int s[3];
    int d;
    s = '{x, y, z};
    align_safe();
    set_in(x, y, z);
    for (int k = 0; k < n; k++) begin
      do wait_edge(); while ((e % DIV) != 0);
      check("valid_low", bus.valid_out, 0);
      for (int i = 0; i < 3; i++) begin
        d = s[i] - bias_m[i];
        if (d >= -16 && d <= 16) d = 0;
        acc_m[i] = acc_m[i] + 32'(d);
      end
      wait_edge();
      check("valid_pulse", bus.valid_out, 1);
      check("pitch", bus.pitch_out, angle_m(0));
      check("roll", bus.roll_out, angle_m(1));
      check("yaw", bus.yaw_out, angle_m(2));
      $display("tick x=%0d y=%0d z=%0d -> pitch=%0d roll=%0d yaw=%0d",
               x, y, z, bus.pitch_out, bus.roll_out, bus.yaw_out);
    end
  endtask

  task automatic pulse_zero();
    align_safe();
    bus.zero_in = 1'b1;
    wait_edge();
    bus.zero_in = 1'b0;
    for (int i = 0; i < 3; i++) acc_m[i] = '0;
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_outputs_zero(tag);
    set_in(0, 0, 0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hold;
    int e0;
    rst_n_in         = 1'b0;
    bus.cal_start_in = 1'b0;
    bus.zero_in      = 1'b0;
    set_in(100, -50, 0);
    #23;
    check_outputs_zero("reset");

    // Constant-rate calibration; same rates afterwards must read as zero.
    @(negedge clk_in);
    rst_n_in = 1'b1;
    calibrate(0, 100, -50, 0, 100, -50, 0);
    run_ticks(10, 100, -50, 0);

    // Asynchronous reset mid-RUN, then again mid-CAL_ACCUM.
    run_ticks(8, 2000, -50, 0);
    reset_pulse("rst_run");
    repeat (100) wait_edge();
    reset_pulse("rst_accum");
    calibrate(0, 0, 0, 0, 0, 0, 0);

    // Integration of a constant rate.
    run_ticks(64, 1000, 0, 0);
    check("pitch_1000", bus.pitch_out, 1000);
    run_ticks(64, 0, 0, -1000);
    check("yaw_m1000", bus.yaw_out, -1000);
    check("pitch_kept", bus.pitch_out, 1000);

    // Randomised rates.
    for (int k = 0; k < 30; k++)
      run_ticks(1, int'($urandom_range(0, 6000)) - 3000,
                   int'($urandom_range(0, 6000)) - 3000,
                   int'($urandom_range(0, 200)) - 100);

    // Zero outside a tick: outputs hold until the next strobe.
    hold = angle_m(0);
    pulse_zero();
    check("zero_hold", bus.pitch_out, hold);
    run_ticks(64, 500, 0, 0);
    check("pitch_500", bus.pitch_out, 500);

    // Zero coincident with a tick: clear wins, strobe still fires.
    while ((e % DIV) != DIV - 1) wait_edge();
    bus.zero_in = 1'b1;
    wait_edge();
    bus.zero_in = 1'b0;
    for (int i = 0; i < 3; i++) acc_m[i] = '0;
    wait_edge();
    check("zero_tick_valid", bus.valid_out, 1);
    check("zero_tick_pitch", bus.pitch_out, 0);
    check("zero_tick_yaw", bus.yaw_out, 0);

    // Deadband edges.
    pulse_zero();
    run_ticks(100, 16, -16, 0);
    check("db16_pitch", bus.pitch_out, 0);
    pulse_zero();
    run_ticks(64, 17, 0, 0);
    check("db17_pitch", bus.pitch_out, 17);

    // Large rates wrap the 16-bit angle.
    pulse_zero();
    run_ticks(80, 32000, -32000, 0);

    // cal_start with zero in RUN: calibration restarts, no strobes until done.
    align_safe();
    bus.cal_start_in = 1'b1;
    bus.zero_in      = 1'b1;
    wait_edge();
    bus.cal_start_in = 1'b0;
    bus.zero_in      = 1'b0;
    e0 = e;
    check("cal_drop", bus.calibrated_out, 0);
    wait_edge();
    check("cal_clear_pitch", bus.pitch_out, 0);
    check("cal_clear_roll", bus.roll_out, 0);

    // Bias floor: 255 zeros and one -1 give bias -1; raw 0 is then +1 -> deadband.
    calibrate(e0, 0, 0, 0, -1, 0, 0);
    run_ticks(20, 0, 0, 0);
    check("floor_pitch", bus.pitch_out, 0);
    run_ticks(64, 16, 0, 0);
    check("floor_bias_pitch", bus.pitch_out, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gyro_integrator.md
Name: gyro_integrator

Overview:
- Sits directly downstream of the MPU-6050 I2C reader (gx/gy/gz raw angular-rate words) and upstream of the renderer's camera orientation input.
- Resynchronises the raw rate words and samples them at a fixed rate.
- Calibrates per-axis zero-rate bias at startup and on request, then integrates bias-corrected rates into 16-bit signed pitch/roll/yaw angles with a one-cycle valid strobe per sample.

Parameters:
- CLK_HZ, 100_000_000, frequency of clk_in in Hz.
- SAMPLE_HZ, 1000, integration sample rate. DIV = CLK_HZ/SAMPLE_HZ; DIV must be at least 4.
- CAL_LOG2, 8, calibration averages 2^CAL_LOG2 samples.
- DEADBAND, 16, a corrected rate with |d| <= DEADBAND is treated as 0.
- SCALE_SHIFT, 6, angle output = accumulator[SCALE_SHIFT+15 : SCALE_SHIFT].

Ports:
- clk_in, input, 1, system clock (100 MHz domain).
- rst_n_in, input, 1, asynchronous active-low reset.
- gx_in, input, 16, signed raw X rate; asynchronous to clk_in (comes from the 50 MHz I2C domain).
- gy_in, input, 16, signed raw Y rate; asynchronous.
- gz_in, input, 16, signed raw Z rate; asynchronous.
- cal_start_in, input, 1, single-cycle pulse to restart calibration.
- zero_in, input, 1, single-cycle pulse to zero all angles.
- pitch_out, output, 16, signed integrated X angle.
- roll_out, output, 16, signed integrated Y angle.
- yaw_out, output, 16, signed integrated Z angle.
- valid_out, output, 1, one-cycle pulse when the angle outputs update.
- calibrated_out, output, 1, high while in RUN.

Behaviour:
- Reset (async, rst_n_in=0):
  - All outputs 0; state CAL_CLEAR.
  - Sample counter, calibration sums, biases and accumulators cleared.
  - Synchroniser registers cleared.
- Input sync: each raw word passes through two flops. The value used on a tick is the 2nd-stage value at that edge.
- Tick generator:
  - Counter runs 0..DIV-1 continuously, wraps, and is never reset by cal_start_in or zero_in.
  - tick=1 for one cycle when counter==DIV-1.
- FSM states: CAL_CLEAR, CAL_ACCUM, CAL_BIAS, RUN.
  - CAL_CLEAR: clear sums (width 16+CAL_LOG2 signed), sample count and accumulators; go to CAL_ACCUM next cycle.
  - CAL_ACCUM: on each tick, sum += sample (sign-extended) and count++. On the tick where count reaches 2^CAL_LOG2, go to CAL_BIAS.
  - CAL_BIAS: bias = sum >>> CAL_LOG2 (arithmetic shift, floors toward -inf); go to RUN next cycle; calibrated_out rises on entry to RUN.
  - RUN: on each tick:
    - d = sample - bias, computed as 17-bit signed with no saturation.
    - If |d| <= DEADBAND then d = 0.
    - acc (32-bit signed) += sign-extended d. acc wraps modulo 2^32.
- Output timing:
  - Angle outputs register acc[SCALE_SHIFT+15:SCALE_SHIFT] and valid_out pulses.
  - Both occur on the cycle after the acc update, i.e. 2 cycles after the tick edge.
  - Outputs hold their value between pulses.
- Outside RUN: valid_out stays 0. pitch/roll/yaw are forced to 0 in CAL_CLEAR and held at 0 through calibration.
- zero_in:
  - In RUN, clears all three acc. If coincident with a tick, the clear wins: the tick's d is discarded and valid_out still pulses with 0 outputs.
  - Ignored outside RUN.
- cal_start_in:
  - From any state, next state is CAL_CLEAR and calibrated_out drops on the next edge.
  - Has priority over zero_in and over a coincident tick.
  - In CAL_ACCUM, restarts the sample count.
- Axis mapping: gx to pitch, gy to roll, gz to yaw. All three axes share the tick, FSM and valid_out.

Decomposition:
- Package gyro_pkg holds:
  - state enum cal_state_t {CAL_CLEAR, CAL_ACCUM, CAL_BIAS, RUN};
  - localparams RATE_W=16, ACC_W=32, ANGLE_W=16.
- One sub-module, gyro_axis_integrator, instantiated 3 times. It owns per-axis synchroniser, cal sum, bias, deadband, acc and output register. It is driven by shared tick/state/zero controls from the top FSM.

Test Plan:
- Calibration, with SAMPLE_HZ sized for DIV=8: hold gx=100, gy=-50, gz=0 -> calibrated_out rises after 256 ticks plus 2 cycles; biases are 100/-50/0; in RUN with the same inputs, pitch/roll/yaw stay 0 and valid_out pulses every 8 cycles.
- Integration, after calibration with bias 0: gx=1000 for 64 ticks -> pitch_out=1000 on the 64th valid_out; gz=-1000 for 64 ticks -> yaw_out=-1000.
- Deadband: d=+16 for 100 ticks -> pitch_out stays 0; d=+17 for 64 ticks -> pitch_out=17 (64*17>>6).
- Bias floor: calibrate with 255 samples of 0 and 1 sample of -1 -> bias=-1; then a raw 0 input gives d=+1, which the deadband discards.
- zero_in on the same cycle as a tick, with pitch=500 -> the next valid_out shows 0; cal_start_in asserted in RUN with zero_in -> calibrated_out=0 next cycle, no valid_out until recalibrated.
- rst_n_in pulsed low asynchronously mid-CAL_ACCUM and mid-RUN -> all outputs 0 immediately; full calibration reruns after release.
